// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port integer register file.
// Imported by the top level and the read-port sub-module.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int ZERO_IDX = 0;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: x0 and not-ready gating, same-cycle write bypass,
// and pending-producer qualification of the scoreboard bit.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            ready,
    input  logic [AW-1:0]   rd_idx,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] arr_data,
    input  logic            arr_busy,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic wr_hit;
    logic is_zero;

    always_comb begin
        wr_hit  = wr_en && (wr_idx == rd_idx);
        is_zero = (rd_idx == AW'(ZERO_IDX));
        rd_data = '0;
        rd_busy = 1'b0;
        if (ready && !is_zero) begin
            // A register being written this cycle already has its value, so it is never busy.
            rd_data = wr_hit ? wr_data : arr_data;
            rd_busy = arr_busy && !wr_hit;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// RV32I integer register file with NREAD read ports, hardwired x0, write bypass,
// a pending-write scoreboard and a post-reset clear sequencer.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2,
    localparam int AW   = idx_width(DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREAD*AW-1:0]   Read_Reg,
    output logic [NREAD*XLEN-1:0] Read_Data,
    output logic [NREAD-1:0]      Read_Busy,
    input  logic                  Write,
    input  logic [AW-1:0]         Write_Reg,
    input  logic [XLEN-1:0]       Write_Data,
    input  logic                  Alloc,
    input  logic [AW-1:0]         Alloc_Reg,
    output logic                  Ready
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  regs_q [DEPTH];

    logic             arr_we;
    logic [AW-1:0]    arr_widx;
    logic [XLEN-1:0]  arr_wdata;

    assign Ready = (state_q == RUN);

    // Clear sequencer and array write port share one mux: CLEAR owns the port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        arr_we    = 1'b0;
        arr_widx  = Write_Reg;
        arr_wdata = Write_Data;
        case (state_q)
            CLEAR: begin
                arr_we    = 1'b1;
                arr_widx  = clr_cnt_q;
                arr_wdata = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                arr_we = Write && (Write_Reg != AW'(ZERO_IDX));
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (arr_we && !Reset) begin
            regs_q[arr_widx] <= arr_wdata;
        end
    end

    // Alloc is applied after Write so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (Ready) begin
            if (Write) begin
                busy_d[Write_Reg] = 1'b0;
            end
            if (Alloc && (Alloc_Reg != AW'(ZERO_IDX))) begin
                busy_d[Alloc_Reg] = 1'b1;
            end
        end
        busy_d[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] rd_idx;
        assign rd_idx = Read_Reg[i*AW +: AW];

        reg_file_read_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_port (
            .ready    (Ready),
            .rd_idx   (rd_idx),
            .wr_en    (Write),
            .wr_idx   (Write_Reg),
            .wr_data  (Write_Data),
            .arr_data (regs_q[rd_idx]),
            .arr_busy (busy_q[rd_idx]),
            .rd_data  (Read_Data[i*XLEN +: XLEN]),
            .rd_busy  (Read_Busy[i])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic
// compared against an array/scoreboard reference model.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic [NREAD*AW-1:0]   Read_Reg;
    logic [NREAD*XLEN-1:0] Read_Data;
    logic [NREAD-1:0]      Read_Busy;
    logic                  Write;
    logic [AW-1:0]         Write_Reg;
    logic [XLEN-1:0]       Write_Data;
    logic                  Alloc;
    logic [AW-1:0]         Alloc_Reg;
    logic                  Ready;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit              m_ready = 1'b0;
    int              m_cnt   = 0;
    logic [XLEN-1:0] m_regs [DEPTH];
    bit              m_busy [DEPTH];

    reg_file_mp #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Read_Reg   (Read_Reg),
        .Read_Data  (Read_Data),
        .Read_Busy  (Read_Busy),
        .Write      (Write),
        .Write_Reg  (Write_Reg),
        .Write_Data (Write_Data),
        .Alloc      (Alloc),
        .Alloc_Reg  (Alloc_Reg),
        .Ready      (Ready)
    );

    always #5 Clock = ~Clock;

    function automatic logic [AW-1:0] port_idx(input int p);
        return Read_Reg[p*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int p);
        logic [AW-1:0] idx;
        idx = port_idx(p);
        if (!m_ready || idx == 0) return '0;
        if (Write && Write_Reg == idx) return Write_Data;
        return m_regs[idx];
    endfunction

    function automatic bit exp_busy(input int p);
        logic [AW-1:0] idx;
        idx = port_idx(p);
        if (!m_ready || idx == 0) return 1'b0;
        return m_busy[idx] && !(Write && Write_Reg == idx);
    endfunction

    task automatic set_rd(input int p, input logic [AW-1:0] idx);
        Read_Reg[p*AW +: AW] = idx;
    endtask

    task automatic idle_inputs();
        Write = 1'b0; Write_Reg = '0; Write_Data = '0;
        Alloc = 1'b0; Alloc_Reg = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        if (Reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
        end else if (!m_ready) begin
            m_regs[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) m_ready = 1'b1;
            m_cnt = (m_cnt + 1) % DEPTH;
        end else begin
            if (Write && Write_Reg != 0) m_regs[Write_Reg] = Write_Data;
            if (Write) m_busy[Write_Reg] = 1'b0;
            if (Alloc && Alloc_Reg != 0) m_busy[Alloc_Reg] = 1'b1;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Read_Reg = '0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            set_rd(0, AW'(c));
            set_rd(1, AW'(DEPTH - 1 - c));
            #1;
            tests++;
            if (Ready !== 1'b0 || Read_Data !== '0 || Read_Busy !== '0) begin
                fails++;
                $display("FAIL reset_clear cycle %0d: ready=%b data=%h busy=%b, need ready=0 data=0 busy=0",
                         c, Ready, Read_Data, Read_Busy);
            end
            step();
        end
        set_rd(0, 5); set_rd(1, 5);
        #1;
        tests++;
        if (Ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b need 1", Ready);
        end
        tests++;
        if (Read_Data[0 +: XLEN] !== 32'h0) begin
            fails++;
            $display("FAIL reset_x5: got %h need 0", Read_Data[0 +: XLEN]);
        end
    endtask

    task automatic test_bypass();
        set_rd(0, 3); set_rd(1, 4);
        Write = 1'b1; Write_Reg = 3; Write_Data = 32'hDEADBEEF;
        #1;
        tests++;
        if (Read_Data[0 +: XLEN] !== 32'hDEADBEEF || Read_Busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL bypass_same_cycle: data=%h busy=%b need DEADBEEF/0", Read_Data[0 +: XLEN], Read_Busy[0]);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (Read_Data[0 +: XLEN] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL bypass_array: got %h need DEADBEEF", Read_Data[0 +: XLEN]);
        end
    endtask

    task automatic test_x0();
        set_rd(0, 0); set_rd(1, 0);
        Write = 1'b1; Write_Reg = 0; Write_Data = 32'hFFFFFFFF;
        Alloc = 1'b1; Alloc_Reg = 0;
        #1;
        for (int p = 0; p < NREAD; p++) begin
            tests++;
            if (Read_Data[p*XLEN +: XLEN] !== 32'h0 || Read_Busy[p] !== 1'b0) begin
                fails++;
                $display("FAIL x0_same port%0d: data=%h busy=%b need 0/0", p, Read_Data[p*XLEN +: XLEN], Read_Busy[p]);
            end
        end
        step();
        idle_inputs();
        #1;
        for (int p = 0; p < NREAD; p++) begin
            tests++;
            if (Read_Data[p*XLEN +: XLEN] !== 32'h0 || Read_Busy[p] !== 1'b0) begin
                fails++;
                $display("FAIL x0_next port%0d: data=%h busy=%b need 0/0", p, Read_Data[p*XLEN +: XLEN], Read_Busy[p]);
            end
        end
    endtask

    task automatic test_scoreboard();
        set_rd(0, 7); set_rd(1, 7);
        Alloc = 1'b1; Alloc_Reg = 7;
        #1;
        tests++;
        if (Read_Busy !== 2'b00) begin
            fails++;
            $display("FAIL alloc_no_comb_path: got %b need 00", Read_Busy);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (Read_Busy !== 2'b11) begin
            fails++;
            $display("FAIL alloc_busy: got %b need 11", Read_Busy);
        end
        Write = 1'b1; Write_Reg = 7; Write_Data = 32'h12;
        #1;
        tests++;
        if (Read_Busy !== 2'b00 || Read_Data[XLEN +: XLEN] !== 32'h12) begin
            fails++;
            $display("FAIL write_clears_busy: busy=%b data=%h need 00/12", Read_Busy, Read_Data[XLEN +: XLEN]);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (Read_Busy !== 2'b00 || Read_Data[0 +: XLEN] !== 32'h12) begin
            fails++;
            $display("FAIL busy_after_write: busy=%b data=%h need 00/12", Read_Busy, Read_Data[0 +: XLEN]);
        end
    endtask

    task automatic test_alloc_write_same();
        set_rd(0, 9); set_rd(1, 9);
        Alloc = 1'b1; Alloc_Reg = 9;
        Write = 1'b1; Write_Reg = 9; Write_Data = 32'h55;
        step();
        idle_inputs();
        #1;
        tests++;
        if (Read_Data[0 +: XLEN] !== 32'h55 || Read_Busy !== 2'b11) begin
            fails++;
            $display("FAIL alloc_write_same: data=%h busy=%b need 55/11", Read_Data[0 +: XLEN], Read_Busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            Write = 1'b1; Write_Reg = 3; Write_Data = 32'hA5A5A5A5;
            Alloc = 1'b1; Alloc_Reg = 4;
            step();
        end
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            Write = 1'b1; Write_Reg = 3; Write_Data = 32'h5A5A5A5A;
            Alloc = 1'b1; Alloc_Reg = 4;
            #1;
            tests++;
            if (Ready !== 1'b0) begin
                fails++;
                $display("FAIL midclear_ready cycle %0d: got %b need 0", c, Ready);
            end
            step();
        end
        idle_inputs();
        set_rd(0, 3); set_rd(1, 4);
        #1;
        tests++;
        if (Ready !== 1'b1 || Read_Data !== '0 || Read_Busy !== 2'b00) begin
            fails++;
            $display("FAIL midclear_after: ready=%b data=%h busy=%b need 1/0/00", Ready, Read_Data, Read_Busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            Reset      = ($urandom_range(0, 199) == 0);
            Write      = $urandom_range(0, 1);
            Write_Reg  = AW'($urandom_range(0, 7));
            Write_Data = $urandom;
            Alloc      = $urandom_range(0, 1);
            Alloc_Reg  = AW'($urandom_range(0, 7));
            for (int p = 0; p < NREAD; p++) set_rd(p, AW'($urandom_range(0, 7)));
            #1;
            tests++;
            if (Ready !== m_ready) begin
                fails++;
                $display("FAIL rand_ready cycle %0d: got %b need %b", c, Ready, m_ready);
            end
            for (int p = 0; p < NREAD; p++) begin
                tests++;
                if (Read_Data[p*XLEN +: XLEN] !== exp_data(p) || Read_Busy[p] !== exp_busy(p)) begin
                    fails++;
                    $display("FAIL rand_read cycle %0d port%0d idx %0d: data=%h busy=%b need %h/%b",
                             c, p, port_idx(p), Read_Data[p*XLEN +: XLEN], Read_Busy[p], exp_data(p), exp_busy(p));
                end
            end
            step();
        end
        Reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        Reset = 1'b0;
        Read_Reg = '0;
        idle_inputs();
        @(posedge Clock);
        #1;
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_alloc_write_same();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RV32I core, the next generation of the existing two-read/one-write file. Adds a configurable number of read ports, hardwired-zero x0, same-cycle write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a post-reset clear sequencer that zeroes every register before the file reports ready. Sits between decode (read/allocate) and writeback (write).

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- NREAD, 2, number of read ports
- AW (derived), $clog2(DEPTH), register index width; not user-overridable
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Read_Reg  in  NREAD*AW  read indices; port i at bits [i*AW +: AW]
- Read_Data  out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
- Read_Busy  out  NREAD  port i's register has a pending producer
- Write  in  1  write enable from writeback
- Write_Reg  in  AW  write index
- Write_Data  in  XLEN  write data
- Alloc  in  1  decode marks a destination as pending
- Alloc_Reg  in  AW  index being allocated
- Ready  out  1  clear sequence finished; file usable

## Operation
- States: CLEAR, RUN.
- Reset high at an edge: state ← CLEAR, clear counter ← 0, scoreboard ← all 0. Applies at any time, including mid-CLEAR (counter restarts at 0).
- CLEAR: each cycle writes 0 to Reg[counter], counter += 1; on the cycle counter == DEPTH-1 the write happens and state ← RUN.
- RUN: Ready = 1. Write && Write_Reg != 0 → Reg[Write_Reg] ← Write_Data. Writes to index 0 are discarded.
- Write and Alloc are ignored (no register, no scoreboard change) while Ready = 0.
- Read port i (combinational): Ready = 0 → 0; Read_Reg = 0 → 0; Write && Write_Reg == Read_Reg != 0 → Write_Data (bypass); else Reg[Read_Reg].
- Scoreboard, one bit per register, bit 0 constant 0. Write clears busy[Write_Reg]. Alloc && Alloc_Reg != 0 sets busy[Alloc_Reg]. Same index in both in the same cycle → set wins (new producer supersedes). Alloc of an already-busy register leaves it busy (no counting).
- Read_Busy[i] = busy[Read_Reg[i]] && !(Write && Write_Reg == Read_Reg[i]); bypassed data is never reported busy. Forced 0 while Ready = 0 and for index 0.
- All NREAD ports are independent; any number may name the same register.

## Timing
- Reset values: Ready 0, Read_Data all 0, Read_Busy all 0.
- Clear latency: Reset high at edge E, low afterwards → Ready rises after edge E+DEPTH (DEPTH CLEAR cycles).
- Read latency: 0 cycles (combinational from Read_Reg, Write, Write_Reg, Write_Data, and state).
- Write visible via bypass in the same cycle; from the array from the next cycle.
- Scoreboard update visible on Read_Busy the cycle after Alloc/Write.
- No combinational path from Alloc to any output.

## Structure
- Package reg_file_pkg: state enum {CLEAR, RUN}, ZERO_IDX constant, and an index-width helper function.
- Sub-module reg_file_read_port: one read mux with x0/Ready gating, bypass compare, and busy qualification; instantiated NREAD times with a generate loop.
- Top level holds the array, scoreboard, clear counter and FSM.

## Test plan
- Reset, DEPTH=32 → Ready low for exactly 32 cycles; all reads return 0 throughout; after Ready, read of x5 = 0.
- Write x3 = 0xDEADBEEF while reading x3 on port 0 → port 0 shows 0xDEADBEEF in the same cycle, Read_Busy[0] = 0; next cycle array value is 0xDEADBEEF.
- Write x0 = 0xFFFFFFFF, read x0 on all ports same and next cycle → 0.
- Alloc x7 → next cycle Read_Busy for x7 = 1; Write x7 = 0x12 → same cycle busy 0 with data 0x12; next cycle busy 0.
- Alloc x9 and Write x9 = 0x55 in the same cycle → next cycle x9 = 0x55 and busy = 1.
- Reset asserted at clear count 10 → counter restarts; Ready rises 32 cycles after the reset edge; Write/Alloc issued during CLEAR have no effect.
